// File: rtl/add_seq_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
// Limb width and FSM state encoding used by the top and its adder.
package add_seq_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/cla16_ripple.sv
// 16-bit adder built from four 4-bit carry-lookahead groups; the group
// carries ripple from one group to the next.
module cla16_ripple
    import add_seq_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin,
    output logic [LIMB_W-1:0] s,
    output logic              cout
);

    logic [LIMB_W-1:0] g;
    logic [LIMB_W-1:0] p;
    logic [LIMB_W:0]   cv;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin : carry_net
        logic grp_cin;
        logic acc;
        logic term;
        cv      = '0;
        cv[0]   = cin;
        grp_cin = cin;
        acc     = 1'b0;
        term    = 1'b0;
        for (int grp = 0; grp < LIMB_W / 4; grp++) begin
            // Each carry inside a group is a flat sum-of-products of the
            // group's generate/propagate terms and the group carry-in.
            for (int j = 1; j <= 4; j++) begin
                acc = grp_cin;
                for (int k = 0; k < j; k++) begin
                    acc = acc & p[4*grp + k];
                end
                for (int k = 0; k < j; k++) begin
                    term = g[4*grp + k];
                    for (int m = k + 1; m < j; m++) begin
                        term = term & p[4*grp + m];
                    end
                    acc = acc | term;
                end
                cv[4*grp + j] = acc;
            end
            grp_cin = cv[4*grp + 4];
        end
    end

    assign s    = p ^ cv[LIMB_W-1:0];
    assign cout = cv[LIMB_W];

endmodule

// File: rtl/add64_seq.sv
// Multi-precision add/subtract sequencer: steps WORDS 16-bit limbs LSB-first
// through one shared cla16_ripple, chaining the carry through a register.
module add64_seq
    import add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sub,
    input  logic [LIMB_W*WORDS-1:0] a,
    input  logic [LIMB_W*WORDS-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic [LIMB_W*WORDS-1:0] sum,
    output logic                    cout,
    output logic                    ovf
);

    localparam int N     = LIMB_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    seq_state_e state_q;
    seq_state_e state_d;

    logic [WORDS-1:0][LIMB_W-1:0] opa_q;
    logic [WORDS-1:0][LIMB_W-1:0] opb_q;
    logic [WORDS-1:0][LIMB_W-1:0] sum_q;
    logic [IDX_W-1:0]             idx_q;
    logic                         carry_q;
    logic                         cout_q;
    logic                         ovf_q;

    logic              load;
    logic              step;
    logic              last;
    logic [LIMB_W-1:0] limb_a;
    logic [LIMB_W-1:0] limb_b;
    logic [LIMB_W-1:0] limb_s;
    logic              limb_cout;
    logic              limb_ovf;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    last    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign limb_a = opa_q[idx_q];
    assign limb_b = opb_q[idx_q];

    cla16_ripple u_cla (
        .a    (limb_a),
        .b    (limb_b),
        .cin  (carry_q),
        .s    (limb_s),
        .cout (limb_cout)
    );

    // opb holds the already-inverted subtrahend, so the sign test is uniform
    assign limb_ovf = (limb_a[LIMB_W-1] == limb_b[LIMB_W-1]) &&
                      (limb_s[LIMB_W-1] != limb_a[LIMB_W-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            opa_q   <= a;
            opb_q   <= b ^ {N{sub}};
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= sub;
        end else if (step) begin
            sum_q[idx_q] <= limb_s;
            carry_q      <= limb_cout;
            if (last) begin
                cout_q <= limb_cout;
                ovf_q  <= limb_ovf;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_add64_seq.sv
// Self-checking bench for add64_seq (WORDS=4): directed cases plus random
// operations compared against a plain-arithmetic reference.
module tb_add64_seq;

    localparam int WORDS = 4;
    localparam int N     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0] last_sum;
    logic         last_cout;
    logic         last_ovf;

    add64_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '1;
            1:       return '0;
            2:       return {1'b1, {(N-1){1'b0}}};
            3:       return {1'b0, {(N-1){1'b1}}};
            4:       return N'($urandom_range(0, 15));
            default: return r64();
        endcase
    endfunction

    // Reference: integer add/subtract; cout is carry-out (add) or "no borrow"
    // (subtract); ovf from a sign-extended signed result.
    task automatic model(input logic [N-1:0] oa, input logic [N-1:0] ob, input logic osub,
                         output logic [N-1:0] r, output logic c, output logic v);
        logic [N:0]        wide;
        logic signed [N:0] sa;
        logic signed [N:0] sb;
        logic signed [N:0] sr;
        sa = $signed({oa[N-1], oa});
        sb = $signed({ob[N-1], ob});
        if (osub) begin
            r  = oa - ob;
            c  = (oa >= ob);
            sr = sa - sb;
        end else begin
            wide = {1'b0, oa} + {1'b0, ob};
            r    = wide[N-1:0];
            c    = wide[N];
            sr   = sa + sb;
        end
        v = sr[N] ^ sr[N-1];
    endtask

    // Called at a falling edge; asserts start there, then follows the
    // operation to its done cycle and returns at that cycle's falling edge.
    task automatic run_op(input logic [N-1:0] oa, input logic [N-1:0] ob, input logic osub,
                          input bit mid_pulse);
        logic [N-1:0] er;
        logic         ec;
        logic         ev;
        bit           seen;
        model(oa, ob, osub, er, ec, ev);
        a     = oa;
        b     = ob;
        sub   = osub;
        start = 1'b1;
        @(posedge clk);
        seen = 1'b0;
        for (int cyc = 1; cyc <= 12 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                a     = r64();
                b     = r64();
                sub   = 1'($urandom_range(0, 1));
                chk("sum_cleared", sum, '0);
            end
            if (mid_pulse && cyc == 2) begin
                start = 1'b1;
                a     = r64();
                b     = r64();
            end
            if (mid_pulse && cyc == 3) start = 1'b0;
            chk("busy", N'(busy), N'(cyc <= WORDS));
            chk("done", N'(done), N'(cyc == WORDS + 1));
            if (cyc >= 2 && cyc <= WORDS)
                chk("partial_sum", sum, er & ((64'd1 << (16 * (cyc - 1))) - 64'd1));
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            chk("done_timeout", N'(0), N'(1));
        end else begin
            chk("sum", sum, er);
            chk("cout", N'(cout), N'(ec));
            chk("ovf", N'(ovf), N'(ev));
        end
        last_sum  = er;
        last_cout = ec;
        last_ovf  = ev;
    endtask

    task automatic idle_gap();
        @(negedge clk);
        chk("done_single", N'(done), N'(0));
        chk("busy_idle", N'(busy), N'(0));
        chk("sum_held", sum, last_sum);
        chk("cout_held", N'(cout), N'(last_cout));
        chk("ovf_held", N'(ovf), N'(last_ovf));
    endtask

    initial begin
        int stray;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", N'(busy), N'(0));
        chk("rst_done", N'(done), N'(0));
        chk("rst_sum", sum, '0);
        chk("rst_cout", N'(cout), N'(0));
        chk("rst_ovf", N'(ovf), N'(0));
        rst = 1'b0;
        @(negedge clk);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        idle_gap();
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        idle_gap();
        run_op(64'd5, 64'd7, 1'b1, 1'b0);
        idle_gap();
        run_op(64'd7, 64'd5, 1'b1, 1'b0);
        idle_gap();
        run_op(64'hDEAD_BEEF_0123_4567, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0, 1'b1);
        run_op(64'h1234, 64'h1, 1'b0, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);

        // Abort mid-operation: cout=1 is left over from the previous result.
        a     = 64'h0001_0001_0001_0001;
        b     = 64'h0002_0002_0002_0002;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", N'(busy), N'(0));
        chk("abort_sum", sum, '0);
        chk("abort_cout", N'(cout), N'(0));
        chk("abort_ovf", N'(ovf), N'(0));
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        chk("abort_no_done", N'(stray), N'(0));
        run_op(64'd3, 64'd4, 1'b0, 1'b0);
        idle_gap();

        // Reset and start together: the start is dropped.
        rst   = 1'b1;
        start = 1'b1;
        a     = r64();
        b     = r64();
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        chk("rst_start_idle", N'(stray), N'(0));
        chk("rst_start_sum", sum, '0);

        for (int i = 0; i < 40; i++) begin
            run_op(pick(), pick(), 1'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle_gap();
        end
        idle_gap();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
